// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : RV32I fetch stage. Owns the PC, issues pipelined requests
//                over req/gnt/rvalid and buffers in-order instructions for decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [10:0]     id_ctrl_key,
    output logic            id_illegal
);

    localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

    logic [XLEN-1:0]       r_fetch_pc;
    logic [XLEN-1:0]       r_pc    [FIFO_DEPTH];
    logic [31:0]           r_instr [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_filled;
    logic [c_PTR_W-1:0]    r_alloc_ptr;
    logic [c_PTR_W-1:0]    r_fill_ptr;
    logic [c_PTR_W-1:0]    r_head_ptr;
    logic [c_CNT_W-1:0]    r_allocated;
    logic [c_CNT_W-1:0]    r_pending;
    logic [c_CNT_W-1:0]    r_drop_cnt;

    logic               w_grant;
    logic               w_drop;
    logic               w_fill;
    logic               w_pop;
    logic [c_CNT_W:0]   w_inflight;
    logic [c_CNT_W:0]   w_inflight_dec;
    logic [c_CNT_W-1:0] w_drop_next;
    logic               w_unused;

    assign w_unused = ^redirect_pc[1:0];

    assign imem_req  = !redirect_valid && (r_allocated < c_DEPTH);
    assign imem_addr = r_fetch_pc;

    assign w_grant = imem_req & imem_gnt;
    assign w_drop  = imem_rvalid & (r_drop_cnt != '0);
    assign w_fill  = imem_rvalid & (r_drop_cnt == '0);
    assign w_pop   = id_valid & id_ready;

    // Everything still owed by memory at a redirect becomes a response to drop;
    // a response arriving in the redirect cycle itself is already accounted for.
    assign w_inflight     = {1'b0, r_drop_cnt} + {1'b0, r_pending};
    assign w_inflight_dec = (w_inflight == '0) ? '0
                          : w_inflight - {{c_CNT_W{1'b0}}, imem_rvalid};
    assign w_drop_next    = w_inflight_dec[c_CNT_W] ? '1 : w_inflight_dec[c_CNT_W-1:0];

    assign id_valid    = r_filled[r_head_ptr];
    assign id_instr    = id_valid ? r_instr[r_head_ptr] : '0;
    assign id_pc       = id_valid ? r_pc[r_head_ptr] : '0;
    assign id_ctrl_key = {id_instr[30], id_instr[14:12], id_instr[6:0]};
    assign id_illegal  = id_valid && (id_instr[1:0] != 2'b11);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc  <= RESET_PC;
            r_filled    <= '0;
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_allocated <= '0;
            r_pending   <= '0;
            r_drop_cnt  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
            end
        end else begin
            if (w_pop) begin
                r_filled[r_head_ptr] <= 1'b0;
                r_head_ptr           <= r_head_ptr + c_PTR_W'(1);
            end

            if (redirect_valid) begin
                r_fetch_pc  <= {redirect_pc[XLEN-1:2], 2'b00};
                r_filled    <= '0;
                r_alloc_ptr <= '0;
                r_fill_ptr  <= '0;
                r_head_ptr  <= '0;
                r_allocated <= '0;
                r_pending   <= '0;
                r_drop_cnt  <= w_drop_next;
            end else begin
                if (w_grant) begin
                    r_pc[r_alloc_ptr] <= r_fetch_pc;
                    r_alloc_ptr       <= r_alloc_ptr + c_PTR_W'(1);
                    r_fetch_pc        <= r_fetch_pc + XLEN'(4);
                end

                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - c_CNT_W'(1);
                end

                if (w_fill) begin
                    r_instr[r_fill_ptr]  <= imem_rdata;
                    r_filled[r_fill_ptr] <= 1'b1;
                    r_fill_ptr           <= r_fill_ptr + c_PTR_W'(1);
                end

                case ({w_grant, w_pop})
                    2'b10:   r_allocated <= r_allocated + c_CNT_W'(1);
                    2'b01:   r_allocated <= r_allocated - c_CNT_W'(1);
                    default: r_allocated <= r_allocated;
                endcase

                case ({w_grant, w_fill})
                    2'b10:   r_pending <= r_pending + c_CNT_W'(1);
                    2'b01:   r_pending <= r_pending - c_CNT_W'(1);
                    default: r_pending <= r_pending;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Randomized scoreboard bench for fetch_unit with a memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam int          c_DEPTH    = 4;
    localparam int          c_CYCLES   = 3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [10:0] id_ctrl_key;
    logic        id_illegal;

    fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (c_RESET_PC),
        .FIFO_DEPTH (c_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_ctrl_key    (id_ctrl_key),
        .id_illegal     (id_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        bit          got;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        bit          live;
        int          rdy;
    } mem_t;

    exp_t        exp_q[$];
    mem_t        mem_q[$];
    logic [31:0] model_pc;
    int          checks = 0;
    int          errors = 0;
    bit          run    = 1'b0;

    // Instruction memory contents: a fixed hash plus two known encodings.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0108) return 32'h40B5_0533;
        if (a == 32'h0000_010C) return 32'h0000_0001;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: scores the decode-side stream against the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (run) begin
                check("id_valid", {31'd0, id_valid},
                      {31'd0, (exp_q.size() > 0) && exp_q[0].got});
                if (!id_valid) begin
                    check("empty_outputs_zero", {20'd0, id_ctrl_key, id_illegal} | id_instr | id_pc, 32'd0);
                end else if (id_ready) begin
                    if (exp_q.size() == 0) begin
                        check("pop_with_nothing_expected", 32'd1, 32'd0);
                    end else begin
                        exp_t        e;
                        logic [31:0] ei;
                        e  = exp_q.pop_front();
                        ei = mem_word(e.pc);
                        check("id_pc", id_pc, e.pc);
                        check("id_instr", id_instr, ei);
                        check("id_ctrl_key", {21'd0, id_ctrl_key},
                              {21'd0, ei[30], ei[14:12], ei[6:0]});
                        check("id_illegal", {31'd0, id_illegal}, {31'd0, ei[1:0] != 2'b11});
                    end
                end
            end
        end
    end

    // Driver plus memory model and fetch-side reference.
    initial begin
        int pg, pr, prdy, predir;
        rst_n          = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        model_pc       = c_RESET_PC;
        repeat (2) @(posedge clk);
        #1;
        check("reset_id_valid", {31'd0, id_valid}, 32'd0);
        check("reset_imem_addr", imem_addr, c_RESET_PC);
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b1;

        for (int c = 0; c < c_CYCLES; c++) begin
            @(negedge clk);
            if (c < 40)       begin pg = 100; pr = 100; prdy = 100; predir = 0; end
            else if (c < 60)  begin pg = 100; pr = 100; prdy = 0;   predir = 0; end
            else if (c < 80)  begin pg = 100; pr = 100; prdy = 100; predir = 0; end
            else if (c < 100) begin pg = 100; pr = 0;   prdy = 100; predir = 0; end
            else if (c < 200) begin pg = 100; pr = 100; prdy = 100; predir = 0; end
            else              begin pg = 70;  pr = 70;  prdy = 70;  predir = 3; end

            imem_gnt = ($urandom_range(0, 99) < pg);
            id_ready = ($urandom_range(0, 99) < prdy);
            if (mem_q.size() > 0 && mem_q[0].rdy <= c && $urandom_range(0, 99) < pr) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_q[0].addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
            if (c == 100) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h0000_0103;
            end else if (c == 150) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'hFFFF_FFF4;
            end else begin
                redirect_valid = ($urandom_range(0, 99) < predir);
                redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'h100 + $urandom_range(0, 15)
                                                             : $urandom;
            end

            #1;
            check("imem_req", {31'd0, imem_req},
                  {31'd0, !redirect_valid && (exp_q.size() < c_DEPTH)});
            if (imem_req) check("imem_addr", imem_addr, model_pc);

            #2;
            if (imem_rvalid) begin
                mem_t m;
                m = mem_q.pop_front();
                if (m.live) begin
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (!exp_q[i].got) begin
                            exp_q[i].got = 1'b1;
                            break;
                        end
                    end
                end
            end
            if (redirect_valid) begin
                exp_q.delete();
                foreach (mem_q[i]) mem_q[i].live = 1'b0;
                model_pc = {redirect_pc[31:2], 2'b00};
            end else if (imem_req && imem_gnt) begin
                mem_t m;
                exp_t e;
                m.addr = imem_addr;
                m.live = 1'b1;
                m.rdy  = c + 1;
                mem_q.push_back(m);
                e.pc  = model_pc;
                e.got = 1'b0;
                exp_q.push_back(e);
                model_pc = model_pc + 32'd4;
            end
        end

        @(negedge clk);
        run = 1'b0;
        #4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Parametrised RV32I instruction-fetch stage sitting between the instruction memory and the decode/control stage of the `Risc_v` core. It owns the program counter, issues pipelined requests over a req/gnt/rvalid memory handshake, and buffers up to `FIFO_DEPTH` in-order instructions with their PCs. It presents a valid/ready stream to decode, including the 11-bit control key {instr[30], funct3, opcode} consumed by `control_unit`. A redirect input flushes the buffer, discards in-flight responses and restarts fetch at a new PC.

## Interface
- `XLEN`, 32, PC/address width.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `FIFO_DEPTH`, 4, buffer entries and maximum outstanding requests; power of two, ≥2.

- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out XLEN: fetch address, word-aligned.
- `imem_gnt` in 1: request accepted this cycle when `imem_req & imem_gnt`.
- `imem_rvalid` in 1: response data valid; responses return in grant order.
- `imem_rdata` in 32: instruction word.
- `redirect_valid` in 1: branch/jump/trap redirect, single-cycle pulse.
- `redirect_pc` in XLEN: new fetch PC; bits [1:0] ignored (treated as 0).
- `id_valid` out 1: head instruction available.
- `id_ready` in 1: decode accepts head when `id_valid & id_ready`.
- `id_instr` out 32: head instruction.
- `id_pc` out XLEN: PC of head instruction.
- `id_ctrl_key` out 11: {id_instr[30], id_instr[14:12], id_instr[6:0]}.
- `id_illegal` out 1: id_instr[1:0] != 2'b11 (compressed/illegal encoding).

## Operation
- State: `fetch_pc`, circular buffer of `FIFO_DEPTH` entries {pc, instr, filled}, pointers alloc/fill/head, `drop_cnt`.
- Request: `imem_req = !redirect_valid && (allocated < FIFO_DEPTH)`; `imem_addr = fetch_pc`. `allocated` counts entries granted but not popped.
- Grant: allocate entry at alloc pointer with pc=`fetch_pc`, filled=0; `fetch_pc += 4` (wraps modulo 2^XLEN).
- Response: if `drop_cnt > 0`, decrement and discard; else write `imem_rdata` into entry at fill pointer, set filled, advance fill pointer.
- Pop: `id_valid` = head entry filled; on `id_valid & id_ready`, advance head, decrement `allocated`.
- Redirect: `fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}`; all entries invalidated, pointers reset, `allocated <= 0`; `drop_cnt <= drop_cnt + (granted-not-yet-responded count) − (imem_rvalid this cycle ? 1 : 0)`, saturating at 0. `drop_cnt` width clog2(FIFO_DEPTH)+1.
- `id_instr`, `id_pc`, `id_ctrl_key`, `id_illegal` read directly from head entry registers; no combinational path from any `imem_*` input to any `id_*` output.

## Timing
- Reset (async assert, sync release): `fetch_pc=RESET_PC`, buffer empty, `drop_cnt=0`; `id_valid=0`, `id_instr=0`, `id_pc=0`, `id_ctrl_key=0`, `id_illegal=0` (outputs gated to 0 when empty); `imem_req=1` from first cycle after release, `imem_addr=RESET_PC`.
- Latency: grant in cycle N, rvalid earliest N+1, `id_valid` high in N+2 at earliest.
- Throughput: one instruction per cycle sustained when memory grants every cycle, responds next cycle, and decode is always ready.
- Full: `allocated == FIFO_DEPTH` → `imem_req=0`; a pop in cycle N re-enables `imem_req` in N+1.
- Redirect cycle: `imem_req=0`; `imem_req` with `redirect_pc` in the following cycle.
- Redirect + rvalid same cycle: that response is discarded.
- Redirect + pop same cycle: the pop completes (decode owns it); buffer flushed afterward.
- Grant + pop same cycle on a full buffer cannot occur (req low when full); grant + pop on non-full buffer: `allocated` unchanged.
- Reset mid-operation: state cleared immediately; post-reset responses are not expected and are discarded only through `drop_cnt` from a redirect (memory must be reset together).

## Test plan
- Reset release, memory grants every cycle with 1-cycle response, `id_ready=1` → `id_pc` sequence 0x0,0x4,0x8… one per cycle, first `id_valid` 2 cycles after first grant.
- `id_ready=0` held → exactly 4 grants (0x0–0xC), then `imem_req=0`; raise `id_ready` → pops 0x0,0x4,0x8,0xC in order, req resumes next cycle at 0x10.
- Redirect to 0x103 with 3 responses in flight → those 3 discarded, next `id_pc=0x100` carrying data returned for address 0x100.
- Redirect coinciding with rvalid and with a pop → popped entry accepted once, rvalid data dropped, no stale PC appears after redirect.
- Instruction 0x40B50533 (sub) → `id_ctrl_key=11'b1_000_0110011`, `id_illegal=0`; word 0x00000001 → `id_illegal=1`.
- `fetch_pc` at 0xFFFF_FFFC granted → next `imem_addr=0x0000_0000`.
